wb_commit_unit: RTL and testbench
=================================

// Module: wb_commit_unit
// PURPOSE
//   Write-back commit end of the pipeline. Consumes the registered wb_* bundle from the MEM/WB
//   pipeline register and commits it into the architectural state:
//   - 32x32 GPR file, with two ID-stage read ports and write-through bypass
//   - HI/LO register pair
//   - LLbit (LL/SC link bit)
//   - retired-write counter
//   Sits between MEM/WB and ID. Replaces separate regfile, hilo and LLbit blocks.
// PARAMETERS
//   CNT_W       32   width of commit_cnt; wraps modulo 2^CNT_W
//   REG_RST_VAL 0    value loaded into GPRs 1..31 and HI/LO on reset
// PORTS
//   clk            in   1   clock, all state updates on posedge
//   rst            in   1   synchronous, active-high reset
//   wb_wd          in   5   GPR write address
//   wb_wreg        in   1   GPR write enable
//   wb_wdata       in   32  GPR write data
//   wb_whilo       in   1   HI/LO write enable (HI and LO are written together)
//   wb_hi / wb_lo  in   32  HI / LO write data
//   wb_LLbit_we    in   1   LLbit write enable
//   wb_LLbit_value in   1   LLbit write value
//   flush          in   1   exception flush; clears LLbit
//   re1 / re2      in   1   read-port enables
//   raddr1/raddr2  in   5   read addresses
//   rdata1/rdata2  out  32  read data, combinational
//   hi_o / lo_o    out  32  current HI / LO
//   LLbit_o        out  1   current LLbit, registered
//   commit_cnt     out  CNT_W  number of commit cycles
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//   - GPR[1..31], HI and LO <= REG_RST_VAL.
//   - LLbit <= 0. commit_cnt <= 0.
//   - rdata1/rdata2 forced to 0 while rst=1.
//   GPR write:
//   - Occurs at posedge when wb_wreg=1 and wb_wd!=0.
//   - GPR[0] is hardwired 0; writes to address 0 are dropped silently.
//   Read port n (combinational), in priority order:
//   1. rst=1 -> 0
//   2. re_n=0 -> 0
//   3. raddr_n==0 -> 0
//   4. wb_wreg=1 and raddr_n==wb_wd -> wb_wdata (same-cycle bypass)
//   5. otherwise -> GPR[raddr_n]
//   - Both ports are independent; the same address on both ports returns identical data.
//   HI/LO:
//   - HI <= wb_hi and LO <= wb_lo at posedge when wb_whilo=1.
//   - Latency to hi_o/lo_o: see CONFIGURATION.
//   LLbit (registered), in priority order:
//   1. rst -> 0
//   2. flush -> 0, even when wb_LLbit_we=1 in the same cycle
//   3. wb_LLbit_we=1 -> wb_LLbit_value
//   4. otherwise hold
//   commit_cnt:
//   - +1 at posedge when (wb_wreg and wb_wd!=0) or wb_whilo or wb_LLbit_we.
//   - One increment per cycle regardless of how many targets are written.
//   - Wraps from 2^CNT_W-1 to 0.
//   flush:
//   - Does not block GPR or HI/LO writes; squashing is done upstream by MEM/WB.
//   Reset mid-operation:
//   - rst has priority over every write arriving in the same cycle. No write commits.
//   - commit_cnt does not increment in that cycle.
//   No handshake: every valid wb_* write is consumed in the cycle it is presented.
//   Stall is handled upstream.
// CONFIGURATION
//   HILO_BYPASS_EN defined:
//   - hi_o = wb_whilo ? wb_hi : HI, and lo_o = wb_whilo ? wb_lo : LO (combinational).
//   - New values are visible in the same cycle.
//   HILO_BYPASS_EN undefined:
//   - hi_o/lo_o are the register outputs only.
//   - New values become visible one cycle after wb_whilo. The EX stage must forward HI/LO itself.
// TESTING
//   1. Reset 2 cycles, re1=re2=1, sweep raddr 0..31
//      -> rdata=0 with REG_RST_VAL=0; hi_o=lo_o=0; LLbit_o=0; commit_cnt=0.
//   2. wb_wreg=1, wb_wd=5, wb_wdata=32'hDEADBEEF, raddr1=5, re1=1
//      -> rdata1=DEADBEEF in the same cycle and all later cycles; commit_cnt=1.
//   3. wb_wreg=1, wb_wd=0, wb_wdata=32'h1234, raddr2=0
//      -> rdata2=0 now and next cycle; commit_cnt unchanged.
//   4. wb_whilo=1, wb_hi=32'h1, wb_lo=32'h2 for one cycle
//      -> with HILO_BYPASS_EN: hi_o=1, lo_o=2 in that cycle;
//         without it: previous values in that cycle, 1 and 2 after the posedge.
//   5. wb_LLbit_we=1, value=1, flush=1 -> LLbit_o=0;
//      next cycle we=1, value=1, flush=0 -> LLbit_o=1;
//      next cycle flush=1 alone -> LLbit_o=0.
//   6. CNT_W=4, 16 consecutive wb_whilo cycles -> commit_cnt counts 1..15 then 0;
//      rst asserted together with a write -> no GPR change, commit_cnt=0.

Source files
------------

// File: rtl/wb_commit_if.sv
// Write-back commit bundle: MEM/WB write fields, flush, ID-stage read ports and
// committed-state outputs of wb_commit_unit.
interface wb_commit_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic [4:0]        wb_wd;
   logic              wb_wreg;
   logic [DATA_W-1:0] wb_wdata;
   logic              wb_whilo;
   logic [DATA_W-1:0] wb_hi;
   logic [DATA_W-1:0] wb_lo;
   logic              wb_LLbit_we;
   logic              wb_LLbit_value;
   logic              flush;
   logic              re1;
   logic              re2;
   logic [4:0]        raddr1;
   logic [4:0]        raddr2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;
   logic              LLbit_o;
   logic [CNT_W-1:0]  commit_cnt;

   // Pipeline side: presents the write-back bundle and read requests.
   modport master (
      output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
             wb_LLbit_we, wb_LLbit_value, flush, re1, re2, raddr1, raddr2,
      input  rdata1, rdata2, hi_o, lo_o, LLbit_o, commit_cnt
   );

   // Commit unit side: owns the architectural state.
   modport slave (
      input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
             wb_LLbit_we, wb_LLbit_value, flush, re1, re2, raddr1, raddr2,
      output rdata1, rdata2, hi_o, lo_o, LLbit_o, commit_cnt
   );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: GPR file with write-through read bypass, HI/LO, LLbit and
// retired-write counter. Optional macro HILO_BYPASS_EN forwards wb_hi/wb_lo to hi_o/lo_o.
module wb_commit_unit #(
   parameter int                DATA_W      = 32,
   parameter int                CNT_W       = 32,
   parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
   input  logic       clk,
   input  logic       rst,
   wb_commit_if.slave bus
);

   logic [DATA_W-1:0] gpr [0:31];
   logic [DATA_W-1:0] hi_reg;
   logic [DATA_W-1:0] lo_reg;
   logic              llbit_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic gpr_we;
   logic commit_evt;

   // Read priority: reset, port disable, $zero, same-cycle write-back, stored value.
   function automatic logic [DATA_W-1:0] read_port(
      input logic              rst_i,
      input logic              re,
      input logic [4:0]        raddr,
      input logic              wreg,
      input logic [4:0]        wd,
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] r;
      r = '0;
      if (rst_i || !re || raddr == 5'd0) begin
         r = '0;
      end else if (wreg && raddr == wd) begin
         r = wdata;
      end else begin
         r = stored;
      end
      return r;
   endfunction

   assign gpr_we     = bus.wb_wreg && (bus.wb_wd != 5'd0);
   assign commit_evt = gpr_we || bus.wb_whilo || bus.wb_LLbit_we;

   // GPR[0] is kept at zero and never written, so reads of it are constant.
   always_ff @(posedge clk) begin
      if (rst) begin
         gpr[0] <= '0;
         for (int i = 1; i < 32; i++) begin
            gpr[i] <= REG_RST_VAL;
         end
      end else if (gpr_we) begin
         gpr[bus.wb_wd] <= bus.wb_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_reg <= REG_RST_VAL;
         lo_reg <= REG_RST_VAL;
      end else if (bus.wb_whilo) begin
         hi_reg <= bus.wb_hi;
         lo_reg <= bus.wb_lo;
      end
   end

   // Flush beats a concurrent LL/SC update so a squashed LL cannot leave a live link.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         llbit_reg <= 1'b0;
      end else if (bus.wb_LLbit_we) begin
         llbit_reg <= bus.wb_LLbit_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (commit_evt) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                                 bus.wb_wdata, gpr[bus.raddr1]);
   assign bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                                 bus.wb_wdata, gpr[bus.raddr2]);

`ifdef HILO_BYPASS_EN
   assign bus.hi_o = bus.wb_whilo ? bus.wb_hi : hi_reg;
   assign bus.lo_o = bus.wb_whilo ? bus.wb_lo : lo_reg;
`else
   // Register outputs only; EX must forward an in-flight HI/LO write itself.
   assign bus.hi_o = hi_reg;
   assign bus.lo_o = lo_reg;
`endif

   assign bus.LLbit_o    = llbit_reg;
   assign bus.commit_cnt = cnt_reg;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit (CNT_W=4 to exercise counter wrap).
module tb_wb_commit_unit;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_commit_if #(.DATA_W(32), .CNT_W(CNT_W)) bus ();

   wb_commit_unit #(.DATA_W(32), .CNT_W(CNT_W), .REG_RST_VAL(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic idle();
      bus.wb_wd = 5'd0; bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
      bus.wb_whilo = 1'b0; bus.wb_hi = 32'h0; bus.wb_lo = 32'h0;
      bus.wb_LLbit_we = 1'b0; bus.wb_LLbit_value = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1; bus.re1 = 1'b1; bus.re2 = 1'b1;
      bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
      step();
      step();
      for (int a = 0; a < 32; a++) begin
         bus.raddr1 = 5'(a); bus.raddr2 = 5'(31 - a);
         #1;
         checks++;
         if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL rst_forced_read a=%0d: rdata1=%h rdata2=%h expected 0", a, bus.rdata1, bus.rdata2);
         end
      end
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         bus.raddr1 = 5'(a); bus.raddr2 = 5'(a);
         #1;
         checks++;
         if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_gpr a=%0d: rdata1=%h rdata2=%h expected 0", a, bus.rdata1, bus.rdata2);
         end
      end
      checks++;
      if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.LLbit_o !== 1'b0 || bus.commit_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: hi=%h lo=%h ll=%b cnt=%0d expected 0 0 0 0",
                  bus.hi_o, bus.lo_o, bus.LLbit_o, bus.commit_cnt);
      end
   endtask

   task automatic test_gpr_write();
      bus.wb_wreg = 1'b1; bus.wb_wd = 5'd5; bus.wb_wdata = 32'hDEADBEEF;
      bus.re1 = 1'b1; bus.raddr1 = 5'd5; bus.re2 = 1'b1; bus.raddr2 = 5'd5;
      #1;
      checks++;
      if (bus.rdata1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_same_cycle: rdata1=%h expected deadbeef", bus.rdata1);
      end
      step();
      idle();
      #1;
      checks++;
      if (bus.rdata1 !== 32'hDEADBEEF || bus.rdata2 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL gpr_stored: rdata1=%h rdata2=%h expected deadbeef", bus.rdata1, bus.rdata2);
      end
      checks++;
      if (bus.commit_cnt !== 4'd1) begin
         errors++;
         $display("FAIL cnt_after_gpr: cnt=%0d expected 1", bus.commit_cnt);
      end
      bus.re1 = 1'b0;
      #1;
      checks++;
      if (bus.rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL re_disabled: rdata1=%h expected 0", bus.rdata1);
      end
      // Overwrite: bypass must win over the stale stored value.
      bus.re1 = 1'b1; bus.raddr2 = 5'd6;
      bus.wb_wreg = 1'b1; bus.wb_wd = 5'd5; bus.wb_wdata = 32'h11111111;
      #1;
      checks++;
      if (bus.rdata1 !== 32'h11111111 || bus.rdata2 !== 32'h0) begin
         errors++;
         $display("FAIL bypass_over_stale: rdata1=%h rdata2=%h expected 11111111 0", bus.rdata1, bus.rdata2);
      end
      step();
      idle();
      #1;
      checks++;
      if (bus.rdata1 !== 32'h11111111 || bus.commit_cnt !== 4'd2) begin
         errors++;
         $display("FAIL overwrite: rdata1=%h cnt=%0d expected 11111111 2", bus.rdata1, bus.commit_cnt);
      end
   endtask

   task automatic test_gpr_zero();
      bus.wb_wreg = 1'b1; bus.wb_wd = 5'd0; bus.wb_wdata = 32'h1234;
      bus.re2 = 1'b1; bus.raddr2 = 5'd0;
      #1;
      checks++;
      if (bus.rdata2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_reg_now: rdata2=%h expected 0", bus.rdata2);
      end
      step();
      idle();
      #1;
      checks++;
      if (bus.rdata2 !== 32'h0 || bus.commit_cnt !== 4'd2) begin
         errors++;
         $display("FAIL zero_reg_next: rdata2=%h cnt=%0d expected 0 2", bus.rdata2, bus.commit_cnt);
      end
   endtask

   task automatic test_hilo();
      bus.wb_whilo = 1'b1; bus.wb_hi = 32'h1; bus.wb_lo = 32'h2;
      #1;
      checks++;
`ifdef HILO_BYPASS_EN
      if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2) begin
         errors++;
         $display("FAIL hilo_same_cycle: hi=%h lo=%h expected 1 2", bus.hi_o, bus.lo_o);
      end
`else
      if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
         errors++;
         $display("FAIL hilo_same_cycle: hi=%h lo=%h expected 0 0", bus.hi_o, bus.lo_o);
      end
`endif
      step();
      idle();
      #1;
      checks++;
      if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2 || bus.commit_cnt !== 4'd3) begin
         errors++;
         $display("FAIL hilo_committed: hi=%h lo=%h cnt=%0d expected 1 2 3", bus.hi_o, bus.lo_o, bus.commit_cnt);
      end
   endtask

   task automatic test_llbit();
      bus.wb_LLbit_we = 1'b1; bus.wb_LLbit_value = 1'b1; bus.flush = 1'b1;
      step();
      checks++;
      if (bus.LLbit_o !== 1'b0 || bus.commit_cnt !== 4'd4) begin
         errors++;
         $display("FAIL ll_flush_wins: ll=%b cnt=%0d expected 0 4", bus.LLbit_o, bus.commit_cnt);
      end
      bus.flush = 1'b0;
      step();
      checks++;
      if (bus.LLbit_o !== 1'b1 || bus.commit_cnt !== 4'd5) begin
         errors++;
         $display("FAIL ll_set: ll=%b cnt=%0d expected 1 5", bus.LLbit_o, bus.commit_cnt);
      end
      idle();
      step();
      checks++;
      if (bus.LLbit_o !== 1'b1) begin
         errors++;
         $display("FAIL ll_hold: ll=%b expected 1", bus.LLbit_o);
      end
      // Flush alone clears the link but does not block a GPR write.
      bus.flush = 1'b1; bus.wb_wreg = 1'b1; bus.wb_wd = 5'd9; bus.wb_wdata = 32'h99;
      step();
      idle();
      bus.re1 = 1'b1; bus.raddr1 = 5'd9;
      #1;
      checks++;
      if (bus.LLbit_o !== 1'b0 || bus.rdata1 !== 32'h99 || bus.commit_cnt !== 4'd6) begin
         errors++;
         $display("FAIL flush_clear: ll=%b r9=%h cnt=%0d expected 0 99 6", bus.LLbit_o, bus.rdata1, bus.commit_cnt);
      end
   endtask

   task automatic test_cnt_wrap();
      rst = 1'b1;
      step();
      rst = 1'b0;
      // All three targets in one cycle still count once.
      bus.wb_wreg = 1'b1; bus.wb_wd = 5'd3; bus.wb_wdata = 32'h3;
      bus.wb_whilo = 1'b1; bus.wb_LLbit_we = 1'b1; bus.wb_LLbit_value = 1'b1;
      step();
      idle();
      checks++;
      if (bus.commit_cnt !== 4'd1) begin
         errors++;
         $display("FAIL cnt_once_per_cycle: cnt=%0d expected 1", bus.commit_cnt);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.wb_whilo = 1'b1; bus.wb_hi = 32'(i + 100); bus.wb_lo = 32'(i);
         step();
         checks++;
         if (bus.commit_cnt !== 4'((i + 1) % 16) || bus.hi_o !== 32'(i + 100)) begin
            errors++;
            $display("FAIL cnt_wrap i=%0d: cnt=%0d hi=%h expected %0d %h", i, bus.commit_cnt, bus.hi_o, (i + 1) % 16, i + 100);
         end
      end
      idle();
   endtask

   task automatic test_rst_with_write();
      bus.wb_wreg = 1'b1; bus.wb_wd = 5'd7; bus.wb_wdata = 32'hAAAA;
      step();
      idle();
      checks++;
      if (bus.commit_cnt !== 4'd1) begin
         errors++;
         $display("FAIL pre_rst_write: cnt=%0d expected 1", bus.commit_cnt);
      end
      rst = 1'b1;
      bus.wb_wreg = 1'b1; bus.wb_wd = 5'd7; bus.wb_wdata = 32'h5555;
      bus.wb_whilo = 1'b1; bus.wb_hi = 32'h77; bus.wb_lo = 32'h88;
      bus.wb_LLbit_we = 1'b1; bus.wb_LLbit_value = 1'b1;
      bus.re1 = 1'b1; bus.raddr1 = 5'd7;
      #1;
      checks++;
      if (bus.rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL rst_over_bypass: rdata1=%h expected 0", bus.rdata1);
      end
      step();
      rst = 1'b0;
      idle();
      #1;
      checks++;
      if (bus.rdata1 !== 32'h0 || bus.commit_cnt !== 4'd0 || bus.hi_o !== 32'h0 || bus.LLbit_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_with_write: r7=%h cnt=%0d hi=%h ll=%b expected 0 0 0 0",
                  bus.rdata1, bus.commit_cnt, bus.hi_o, bus.LLbit_o);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.re1 = 1'b0; bus.re2 = 1'b0; bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
      idle();
      test_reset();
      test_gpr_write();
      test_gpr_zero();
      test_hilo();
      test_llbit();
      test_cnt_wrap();
      test_rst_with_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
